width_16to24: RTL and testbench
===============================

WIDTH_16TO24 -- requirements
Module: width_16to24

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset; asynchronous, active-high (block is in reset while rst_n = 1).
REQ-003 valid_in  input  1  qualifies data_in for one cycle; no backpressure, every qualified word SHALL be accepted.
REQ-004 data_in  input  16  input word from the 8-to-16 packing stage; bits [15:8] are the earlier byte.
REQ-005 valid_out  output  1  registered; high for exactly one cycle per completed 24-bit word.
REQ-006 data_out  output  24  registered output word; bits [23:16] are the earliest byte.
REQ-007 flush  input  1  present only with WIDTH_16TO24_FLUSH_EN; requests emission of buffered residue.
REQ-008 bytes_out  output  2  present only with WIDTH_16TO24_FLUSH_EN; number of valid bytes in data_out (3 = full word, 2 or 1 = flushed residue).

Function
REQ-009 Byte order SHALL be preserved: output stream is the input byte stream regrouped into 3-byte words, MSB first.
REQ-010 The block SHALL use a 3-state machine: S0 (0 bytes buffered), S1 (2 bytes buffered), S2 (1 byte buffered).
REQ-011 S0 + valid_in: store data_in[15:0] into residue; next state S1; no output.
REQ-012 S1 + valid_in: data_out <= {residue[15:0], data_in[15:8]}, valid_out <= 1; store data_in[7:0]; next state S2.
REQ-013 S2 + valid_in: data_out <= {residue[7:0], data_in[15:0]}, valid_out <= 1; next state S0.
REQ-014 valid_in low: state and residue SHALL hold; valid_out <= 0; data_out holds its last value.
REQ-015 Latency: valid_out SHALL assert on the clock edge following the edge that samples the completing input word (one cycle).
REQ-016 Steady state: every 3 accepted inputs SHALL yield exactly 2 outputs; gaps in valid_in SHALL not alter output content.
REQ-017 Residue register SHALL be 16 bits; unused residue bits are don't-care and SHALL never appear in data_out.

Reset
REQ-018 While rst_n = 1: state = S0, residue = 0, valid_out = 0, data_out = 24'h000000, bytes_out = 0 (when present).
REQ-019 Reset asserted mid-word SHALL discard buffered residue; no partial word SHALL be emitted on or after reset release.
REQ-020 First valid_in after reset release SHALL be treated as the first two bytes of a new word.

Configuration
REQ-021 Macro WIDTH_16TO24_FLUSH_EN defined: flush and bytes_out ports exist; full words SHALL drive bytes_out = 3.
REQ-022 With macro, flush = 1 and valid_in = 0 in S1: data_out <= {residue[15:0], 8'h00}, bytes_out <= 2, valid_out <= 1, next state S0.
REQ-023 With macro, flush = 1 and valid_in = 0 in S2: data_out <= {residue[7:0], 16'h0000}, bytes_out <= 1, valid_out <= 1, next state S0.
REQ-024 With macro, flush in S0 SHALL have no effect; flush with valid_in = 1 SHALL be ignored (valid_in processed per REQ-011..013).
REQ-025 Macro undefined: no flush/bytes_out ports; residue is held indefinitely until completed by further input.

Verification
REQ-026 Reset asserted -> valid_out = 0, data_out = 24'h000000, state S0; release with valid_in low -> no output.
REQ-027 Back-to-back 16'h1122, 16'h3344, 16'h5566 -> 24'h112233 one cycle after 2nd input, 24'h445566 one cycle after 3rd.
REQ-028 Same three words with 2-cycle idle gaps between them -> identical outputs, each valid_out single-cycle.
REQ-029 16'hAAAA, then reset pulse, then 16'h0102, 16'h0304, 16'h0506 -> outputs 24'h010203, 24'h040506 only; no AA byte ever emitted.
REQ-030 FLUSH_EN: 16'hABCD then flush -> 24'hABCD00, bytes_out = 2; then 16'h1122, 16'h3344, flush -> 24'h112233 (3), 24'h440000 (1).
REQ-031 Six back-to-back words 16'h0001..16'h0006 -> four outputs 24'h000100, 24'h020003, 24'h000400, 24'h050006.

Source files
------------

// File: rtl/width_16to24.sv
// width_16to24: regroups a stream of 16-bit words into 24-bit words,
// preserving byte order (earliest byte in the most significant position).
//
// Optional feature: define WIDTH_16TO24_FLUSH_EN to add the flush input and
// the bytes_out output, which allow buffered residue to be emitted as a
// partial, zero-padded word.
//
// Handshake: valid_in qualifies data_in for a single cycle and there is no
// backpressure, so every qualified word is consumed on the edge that samples
// it. valid_out is a one-cycle pulse per emitted word; data_out holds its
// last value between pulses.
//
// Reset: rst_n is asynchronous and active-high (the block is held in reset
// while rst_n = 1). Reset discards any buffered residue.
module width_16to24 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [15:0] data_in,
`ifdef WIDTH_16TO24_FLUSH_EN
    input  logic        flush,
    output logic [1:0]  bytes_out,
`endif
    output logic        valid_out,
    output logic [23:0] data_out,
    output logic [1:0]  state_dbg_o
);

    // S0: nothing buffered, S1: two bytes buffered, S2: one byte buffered.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] residue_q;
    logic        valid_out_q;
    logic [23:0] data_out_q;
`ifdef WIDTH_16TO24_FLUSH_EN
    logic [1:0]  bytes_out_q;
`endif

    // Packing FSM: state, residue and all outputs are updated together so the
    // outputs are registered and appear one cycle after the completing input.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S0;
            residue_q   <= 16'h0000;
            valid_out_q <= 1'b0;
            data_out_q  <= 24'h000000;
`ifdef WIDTH_16TO24_FLUSH_EN
            bytes_out_q <= 2'd0;
`endif
        end else begin
            // Default: no output this cycle; data_out keeps its last word.
            valid_out_q <= 1'b0;
            if (valid_in) begin
                case (state_q)
                    S0: begin
                        // Both bytes become the head of a new word.
                        residue_q <= data_in;
                        state_q   <= S1;
                    end
                    S1: begin
                        // Two buffered bytes plus the earlier incoming byte;
                        // the later incoming byte is kept for the next word.
                        // residue_q[15:8] becomes stale and is never read in S2.
                        data_out_q     <= {residue_q, data_in[15:8]};
                        valid_out_q    <= 1'b1;
                        residue_q[7:0] <= data_in[7:0];
                        state_q        <= S2;
`ifdef WIDTH_16TO24_FLUSH_EN
                        bytes_out_q    <= 2'd3;
`endif
                    end
                    S2: begin
                        // One buffered byte completes with both incoming bytes.
                        data_out_q  <= {residue_q[7:0], data_in};
                        valid_out_q <= 1'b1;
                        state_q     <= S0;
`ifdef WIDTH_16TO24_FLUSH_EN
                        bytes_out_q <= 2'd3;
`endif
                    end
                    default: begin
                        state_q <= S0;
                    end
                endcase
`ifdef WIDTH_16TO24_FLUSH_EN
            end else if (flush) begin
                // Flush only acts when residue exists; a flush arriving
                // together with valid_in is ignored by the branch above.
                case (state_q)
                    S1: begin
                        data_out_q  <= {residue_q, 8'h00};
                        bytes_out_q <= 2'd2;
                        valid_out_q <= 1'b1;
                        state_q     <= S0;
                    end
                    S2: begin
                        data_out_q  <= {residue_q[7:0], 16'h0000};
                        bytes_out_q <= 2'd1;
                        valid_out_q <= 1'b1;
                        state_q     <= S0;
                    end
                    default: begin
                        state_q <= S0;
                    end
                endcase
`endif
            end
        end
    end

    assign valid_out   = valid_out_q;
    assign data_out    = data_out_q;
    assign state_dbg_o = state_q;
`ifdef WIDTH_16TO24_FLUSH_EN
    assign bytes_out   = bytes_out_q;
`endif

endmodule

// File: tb/tb_width_16to24.sv
// Testbench for width_16to24. A byte-queue reference model turns every
// accepted input into bytes and produces expected 24-bit words in order;
// a scoreboard matches each valid_out pulse against that queue, and the
// scenario tasks additionally check the literal values and exact cycles.
module tb_width_16to24;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [15:0] data_in;
    logic        valid_out;
    logic [23:0] data_out;
    logic [1:0]  state_dbg;
`ifdef WIDTH_16TO24_FLUSH_EN
    logic        flush;
    logic [1:0]  bytes_out;
`endif

    always #5 clk = ~clk;

    width_16to24 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .data_in     (data_in),
`ifdef WIDTH_16TO24_FLUSH_EN
        .flush       (flush),
        .bytes_out   (bytes_out),
`endif
        .valid_out   (valid_out),
        .data_out    (data_out),
        .state_dbg_o (state_dbg)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    // byte_q: bytes accepted but not yet emitted, earliest first.
    // exp_q : expected output words, {byte_count[1:0], data[23:0]}.
    logic [7:0]  byte_q[$];
    logic [25:0] exp_q[$];

    function automatic void model_push(input logic [15:0] w);
        logic [7:0] b0, b1, b2;
        byte_q.push_back(w[15:8]);
        byte_q.push_back(w[7:0]);
        while (byte_q.size() >= 3) begin
            b0 = byte_q.pop_front();
            b1 = byte_q.pop_front();
            b2 = byte_q.pop_front();
            exp_q.push_back({2'd3, b0, b1, b2});
        end
    endfunction

`ifdef WIDTH_16TO24_FLUSH_EN
    function automatic void model_flush();
        logic [7:0] b0, b1;
        if (byte_q.size() == 2) begin
            b0 = byte_q.pop_front();
            b1 = byte_q.pop_front();
            exp_q.push_back({2'd2, b0, b1, 8'h00});
        end else if (byte_q.size() == 1) begin
            b0 = byte_q.pop_front();
            exp_q.push_back({2'd1, b0, 16'h0000});
        end
    endfunction
`endif

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [25:0] e;
        if (valid_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: got data_out=%h, expected no output", data_out);
            end else begin
                e = exp_q.pop_front();
`ifdef WIDTH_16TO24_FLUSH_EN
                if (data_out !== e[23:0] || bytes_out !== e[25:24]) begin
                    errors++;
                    $display("FAIL scoreboard_word: got %h/%0d, expected %h/%0d",
                             data_out, bytes_out, e[23:0], e[25:24]);
                end
`else
                if (data_out !== e[23:0]) begin
                    errors++;
                    $display("FAIL scoreboard_word: got %h, expected %h", data_out, e[23:0]);
                end
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; outputs are read 1 time unit after
    // the rising edge that sampled them. Inputs return to idle afterwards.
    task automatic drive(input logic v, input logic [15:0] d);
        @(negedge clk);
        valid_in = v;
        data_in  = d;
        if (v) model_push(d);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

`ifdef WIDTH_16TO24_FLUSH_EN
    task automatic drive_f(input logic v, input logic [15:0] d, input logic f);
        @(negedge clk);
        valid_in = v;
        data_in  = d;
        flush    = f;
        if (v) model_push(d);
        else if (f) model_flush();
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        flush    = 1'b0;
    endtask
`endif

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0000);
    endtask

    task automatic expect_out(input string name, input logic v, input logic [23:0] d);
        // Inline single-point check of the pulse and, when pulsing, the word.
        checks++;
        if (valid_out !== v || (v && data_out !== d)) begin
            errors++;
            $display("FAIL %s: got valid_out=%b data_out=%h, expected valid_out=%b data_out=%h",
                     name, valid_out, data_out, v, d);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        valid_in = 1'b0;
`ifdef WIDTH_16TO24_FLUSH_EN
        flush = 1'b0;
`endif
        rst_n = 1'b1;
        byte_q.delete();
        exp_q.delete();
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 24'h000000 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got valid_out=%b data_out=%h state=%0d, expected 0/000000/0",
                     valid_out, data_out, state_dbg);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
    endtask

    task automatic check_drained(input string name);
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d words still outstanding, expected 0", name, exp_q.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n    = 1'b1;
        valid_in = 1'b0;
        data_in  = 16'h0000;
`ifdef WIDTH_16TO24_FLUSH_EN
        flush    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 24'h000000 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: got valid_out=%b data_out=%h state=%0d, expected 0/000000/0",
                     valid_out, data_out, state_dbg);
        end
`ifdef WIDTH_16TO24_FLUSH_EN
        checks++;
        if (bytes_out !== 2'd0) begin
            errors++;
            $display("FAIL reset_bytes_out: got %0d, expected 0", bytes_out);
        end
`endif
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'hFFFF);
            expect_out("release_idle", 1'b0, 24'h0);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 16'h1122); expect_out("b2b_first",  1'b0, 24'h0);
        drive(1'b1, 16'h3344); expect_out("b2b_word0",  1'b1, 24'h112233);
        drive(1'b1, 16'h5566); expect_out("b2b_word1",  1'b1, 24'h445566);
        drive(1'b0, 16'h0000); expect_out("b2b_after",  1'b0, 24'h0);
        checks++;
        if (data_out !== 24'h445566) begin
            errors++;
            $display("FAIL b2b_hold: got data_out=%h, expected 445566", data_out);
        end
        check_drained("b2b");
    endtask

    task automatic test_gaps();
        drive(1'b1, 16'h1122); idle(2);
        drive(1'b1, 16'h3344); expect_out("gap_word0", 1'b1, 24'h112233);
        drive(1'b0, 16'h0000); expect_out("gap_pulse0", 1'b0, 24'h0);
        idle(1);
        drive(1'b1, 16'h5566); expect_out("gap_word1", 1'b1, 24'h445566);
        drive(1'b0, 16'h0000); expect_out("gap_pulse1", 1'b0, 24'h0);
        check_drained("gap");
    endtask

    task automatic test_reset_mid_word();
        drive(1'b1, 16'hAAAA);
        do_reset();
        drive(1'b0, 16'h0000); expect_out("rst_release", 1'b0, 24'h0);
        drive(1'b1, 16'h0102); expect_out("rst_first",   1'b0, 24'h0);
        drive(1'b1, 16'h0304); expect_out("rst_word0",   1'b1, 24'h010203);
        drive(1'b1, 16'h0506); expect_out("rst_word1",   1'b1, 24'h040506);
        check_drained("rst");
    endtask

    task automatic test_six_words();
        drive(1'b1, 16'h0001); expect_out("six_1", 1'b0, 24'h0);
        drive(1'b1, 16'h0002); expect_out("six_2", 1'b1, 24'h000100);
        drive(1'b1, 16'h0003); expect_out("six_3", 1'b1, 24'h020003);
        drive(1'b1, 16'h0004); expect_out("six_4", 1'b0, 24'h0);
        drive(1'b1, 16'h0005); expect_out("six_5", 1'b1, 24'h000400);
        drive(1'b1, 16'h0006); expect_out("six_6", 1'b1, 24'h050006);
        check_drained("six");
    endtask

`ifdef WIDTH_16TO24_FLUSH_EN
    task automatic expect_bytes(input string name, input logic [1:0] b);
        checks++;
        if (bytes_out !== b) begin
            errors++;
            $display("FAIL %s: got bytes_out=%0d, expected %0d", name, bytes_out, b);
        end
    endtask

    task automatic test_flush();
        drive_f(1'b0, 16'h0000, 1'b1); expect_out("flush_s0", 1'b0, 24'h0);
        drive_f(1'b1, 16'hABCD, 1'b0);
        drive_f(1'b0, 16'h0000, 1'b1); expect_out("flush_s1", 1'b1, 24'hABCD00);
        expect_bytes("flush_s1_bytes", 2'd2);
        drive_f(1'b1, 16'h1122, 1'b0);
        drive_f(1'b1, 16'h3344, 1'b0); expect_out("flush_full", 1'b1, 24'h112233);
        expect_bytes("flush_full_bytes", 2'd3);
        drive_f(1'b0, 16'h0000, 1'b1); expect_out("flush_s2", 1'b1, 24'h440000);
        expect_bytes("flush_s2_bytes", 2'd1);
        // Flush together with valid_in is ignored.
        drive_f(1'b1, 16'h7788, 1'b1); expect_out("flush_with_valid", 1'b0, 24'h0);
        drive_f(1'b1, 16'h99AA, 1'b1); expect_out("flush_with_valid2", 1'b1, 24'h778899);
        drive_f(1'b0, 16'h0000, 1'b1); expect_out("flush_tail", 1'b1, 24'hAA0000);
        check_drained("flush");
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
`ifdef WIDTH_16TO24_FLUSH_EN
                drive_f(($urandom_range(0, 2) != 0), 16'($urandom), ($urandom_range(0, 5) == 0));
`else
                drive(($urandom_range(0, 2) != 0), 16'($urandom));
`endif
            end
        end
        // Complete any partial word so every accepted byte reaches the output.
        while (byte_q.size() != 0) drive(1'b1, 16'($urandom));
        check_drained("random");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_reset_mid_word();
        test_six_words();
`ifdef WIDTH_16TO24_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time budget");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
